// File: rtl/fp_to_fixed_conv_if.sv
// Valid/ready bundle between the float multiplier result and the fixed-point datapath.
// The slave modport is the converter view; the master modport is the producer/consumer view.
interface fp_to_fixed_conv_if #(
    parameter int EXP    = 5,
    parameter int FRA    = 10,
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [EXP+FRA:0]          in_data;
    logic [2:0]                in_flag;
    logic                      out_valid;
    logic                      out_ready;
    logic [INT_W+FRAC_W-1:0]   out_data;
    logic [2:0]                out_flag;
    logic [2:0]                out_stat;

    modport slave (
        input  in_valid, in_data, in_flag, out_ready,
        output in_ready, out_valid, out_data, out_flag, out_stat
    );

    modport master (
        output in_valid, in_data, in_flag, out_ready,
        input  in_ready, out_valid, out_data, out_flag, out_stat
    );
endinterface

// File: rtl/fp_to_fixed_conv.sv
// Two-stage float to signed Qm.n converter: decode/align, then round/saturate/sign.
// Rounds to nearest with ties away from zero; saturates on overflow and Inf.
module fp_to_fixed_conv #(
    parameter int EXP    = 5,
    parameter int FRA    = 10,
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    fp_to_fixed_conv_if.slave  bus
);
    localparam int OW   = INT_W + FRAC_W;
    localparam int MW   = OW + 1;
    localparam int SIGW = FRA + 1;
    localparam int LW   = SIGW + OW;
    localparam int SHW  = 16;
    localparam int BIAS = (1 << (EXP - 1)) - 1;

    localparam logic signed [SHW-1:0] SH_OFF = SHW'(FRAC_W - FRA - BIAS);
    localparam logic [MW-1:0] NEG_LIM = MW'(1) << (OW - 1);
    localparam logic [MW-1:0] POS_LIM = NEG_LIM - MW'(1);

    typedef enum logic [1:0] {
        CL_FIN,
        CL_ZERO,
        CL_INF,
        CL_NAN
    } cls_e;

    logic            dsign;
    logic [EXP-1:0]  dexp;
    logic [FRA-1:0]  dman;
    logic [EXP-1:0]  exp_eff;
    logic [SIGW-1:0] sig;
    logic signed [SHW-1:0] sh;
    logic [SHW-1:0]  ush;
    logic [SHW-1:0]  rsh;
    logic [LW-1:0]   lsh;
    logic [2*SIGW-1:0] rext;
    logic [MW-1:0]   dec_mag;
    logic            dec_g;
    logic            dec_s;
    logic            dec_povf;
    cls_e            dec_cls;

    logic            s1_valid_q, s1_valid_d;
    logic            s1_sign_q, s1_sign_d;
    logic [MW-1:0]   s1_mag_q, s1_mag_d;
    logic            s1_g_q, s1_g_d;
    logic            s1_s_q, s1_s_d;
    logic            s1_povf_q, s1_povf_d;
    cls_e            s1_cls_q, s1_cls_d;
    logic [2:0]      s1_flag_q, s1_flag_d;

    logic            s2_valid_q, s2_valid_d;
    logic [OW-1:0]   s2_data_q, s2_data_d;
    logic [2:0]      s2_flag_q, s2_flag_d;
    logic [2:0]      s2_stat_q, s2_stat_d;

    logic            s1_adv;
    logic            s2_adv;
    logic [MW-1:0]   rnd;
    logic [MW-1:0]   lim;
    logic [OW-1:0]   sat;
    logic [OW-1:0]   res;
    logic            r_nan;
    logic            r_ovf;
    logic            r_inx;

    assign {dsign, dexp, dman} = bus.in_data;

    // Align so the magnitude LSB carries weight 2^-FRAC_W.
    always_comb begin
        dec_cls  = CL_FIN;
        sig      = {1'b1, dman};
        exp_eff  = dexp;
        if (dexp == '0) begin
            sig     = {1'b0, dman};
            exp_eff = EXP'(1);
            dec_cls = (dman == '0) ? CL_ZERO : CL_FIN;
        end else if (dexp == '1) begin
            dec_cls = (dman == '0) ? CL_INF : CL_NAN;
        end
        sh       = $signed({{(SHW-EXP){1'b0}}, exp_eff}) + SH_OFF;
        ush      = sh;
        rsh      = -ush;
        lsh      = '0;
        rext     = '0;
        dec_mag  = '0;
        dec_g    = 1'b0;
        dec_s    = 1'b0;
        dec_povf = 1'b0;
        if (!sh[SHW-1]) begin
            if (ush > SHW'(OW)) begin
                dec_povf = 1'b1;
            end else begin
                lsh      = LW'(sig) << ush;
                dec_povf = |lsh[LW-1:OW];
                dec_mag  = lsh[OW:0];
            end
        end else if (rsh > SHW'(SIGW)) begin
            dec_s = |sig;
        end else begin
            rext    = {sig, {SIGW{1'b0}}} >> rsh;
            dec_mag = MW'(rext[2*SIGW-1:SIGW]);
            dec_g   = rext[SIGW-1];
            dec_s   = |rext[SIGW-2:0];
        end
    end

    assign s2_adv       = bus.out_ready | !s2_valid_q;
    assign s1_adv       = !s1_valid_q | s2_adv;
    assign bus.in_ready = s1_adv;

    always_comb begin
        rnd   = s1_mag_q + MW'(s1_g_q);
        lim   = s1_sign_q ? NEG_LIM : POS_LIM;
        sat   = s1_sign_q ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        res   = s1_sign_q ? -rnd[OW-1:0] : rnd[OW-1:0];
        r_nan = 1'b0;
        r_ovf = 1'b0;
        r_inx = s1_g_q | s1_s_q;
        unique case (s1_cls_q)
            CL_NAN: begin
                res   = '0;
                r_nan = 1'b1;
                r_inx = 1'b0;
            end
            CL_ZERO: begin
                res   = '0;
                r_inx = 1'b0;
            end
            CL_INF: begin
                res   = sat;
                r_ovf = 1'b1;
                r_inx = 1'b0;
            end
            CL_FIN: begin
                if (s1_povf_q || (rnd > lim)) begin
                    res   = sat;
                    r_ovf = 1'b1;
                    r_inx = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s1_g_d     = s1_g_q;
        s1_s_d     = s1_s_q;
        s1_povf_d  = s1_povf_q;
        s1_cls_d   = s1_cls_q;
        s1_flag_d  = s1_flag_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_flag_d  = s2_flag_q;
        s2_stat_d  = s2_stat_q;
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_d = dsign;
                s1_mag_d  = dec_mag;
                s1_g_d    = dec_g;
                s1_s_d    = dec_s;
                s1_povf_d = dec_povf;
                s1_cls_d  = dec_cls;
                s1_flag_d = bus.in_flag;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = res;
                s2_flag_d = s1_flag_q;
                s2_stat_d = {r_nan, r_ovf, r_inx};
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            s1_g_q     <= 1'b0;
            s1_s_q     <= 1'b0;
            s1_povf_q  <= 1'b0;
            s1_cls_q   <= CL_ZERO;
            s1_flag_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_flag_q  <= '0;
            s2_stat_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_g_q     <= s1_g_d;
            s1_s_q     <= s1_s_d;
            s1_povf_q  <= s1_povf_d;
            s1_cls_q   <= s1_cls_d;
            s1_flag_q  <= s1_flag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_flag_q  <= s2_flag_d;
            s2_stat_q  <= s2_stat_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_flag  = s2_flag_q;
    assign bus.out_stat  = s2_stat_q;
endmodule
